x_scope_dump: RTL and testbench



---
 rtl/x_scope_dump_pkg.sv | 28 ++
 rtl/x_word_ser.sv | 41 ++++
 rtl/x_scope_dump.sv | 210 +++++++++++++++++++++
 tb/tb_x_scope_dump.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/x_scope_dump_pkg.sv
// Shared types and constants for the scope dump readout controller.
// Optional header feature is enabled by defining X_SCOPE_DUMP_HDR_EN.
package x_scope_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SCOPE = 3'd1,
    ST_HDR        = 3'd2,
    ST_READ       = 3'd3,
    ST_LATCH      = 3'd4,
    ST_SEND       = 3'd5,
    ST_DONE       = 3'd6
  } state_e;

  // Sync byte that opens the optional dump header.
  localparam logic [7:0] HDR_SYNC       = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;
  // Index of the final byte for a data word and for the 3-byte header.
  localparam logic [1:0] WORD_LAST_IDX  = 2'(BYTES_PER_WORD - 1);
  localparam logic [1:0] HDR_LAST_IDX   = 2'd2;

  // Pick byte idx out of a 32-bit word, byte 0 being the LSB.
  function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                          input logic [1:0]  idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/x_word_ser.sv
// Word serialiser: holds a 32-bit word and presents it one byte at a time,
// LSB first. The number of bytes is set at load via the last-byte index so
// the same block also emits the 3-byte dump header.
module x_word_ser
  import x_scope_dump_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic [1:0]  i_last_idx,
  input  logic        i_adv,
  output logic [7:0]  o_data,
  output logic        o_last
);

  logic [31:0] word_r;
  logic [1:0]  idx_r;
  logic [1:0]  last_idx_r;

  // Word/index registers: load restarts at byte 0, an accepted byte advances.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      word_r     <= 32'h0000_0000;
      idx_r      <= 2'd0;
      last_idx_r <= 2'd0;
    end else if (i_load) begin
      word_r     <= i_word;
      idx_r      <= 2'd0;
      last_idx_r <= i_last_idx;
    end else if (i_adv && !o_last) begin
      idx_r      <= idx_r + 2'd1;
    end else begin
      idx_r      <= idx_r;
    end
  end

  assign o_data = byte_sel(word_r, idx_r);
  assign o_last = (idx_r == last_idx_r);

endmodule

// File: rtl/x_scope_dump.sv
// Scope capture memory readout: waits for the scope to go idle, reads an
// inclusive (wrapping) address range and streams each word LSB-first to the
// UART transmitter over a valid/accept handshake.
// Define X_SCOPE_DUMP_HDR_EN to prefix the dump with A5, count[7:0], count[15:8].
module x_scope_dump
  import x_scope_dump_pkg::*;
#(
  parameter int p_addr_w = 11
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [p_addr_w-1:0] i_first,
  input  logic [p_addr_w-1:0] i_last,
  output logic                o_busy,
  output logic                o_done,
  input  logic                i_scope_busy,
  output logic                o_scope_ren,
  output logic [p_addr_w-1:0] o_scope_raddr,
  input  logic [31:0]         i_scope_rdata,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_accept
);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [p_addr_w-1:0] addr_r;
  logic [p_addr_w-1:0] end_r;
  logic                abort_pend_r;

  logic                tx_active_s;
  logic                byte_taken_s;
  logic                stop_s;
  logic                addr_inc_s;
  logic                ser_load_s;
  logic [31:0]         ser_word_s;
  logic [1:0]          ser_last_idx_s;
  logic [7:0]          ser_data_s;
  logic                ser_last_s;

`ifdef X_SCOPE_DUMP_HDR_EN
  // One more bit than the address so a full-memory dump (2^p_addr_w) fits.
  logic [p_addr_w:0]   count_r;
  logic [p_addr_w-1:0] span_s;
  logic [15:0]         count16_s;

  assign span_s    = i_last - i_first;
  assign count16_s = 16'(count_r);

  // Word count for the header, captured together with the range.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_r <= '0;
    end else if ((state_r == ST_IDLE) && i_start) begin
      count_r <= {1'b0, span_s} + {{p_addr_w{1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end
`endif

  // A byte is on the wire in SEND and HDR; it is consumed on accept.
  assign tx_active_s  = (state_r == ST_SEND) || (state_r == ST_HDR);
  assign byte_taken_s = tx_active_s && i_tx_accept;
  // An abort seen at any time during a byte still ends the dump once it leaves.
  assign stop_s       = i_abort || abort_pend_r;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Range registers: loaded on an accepted start, address walks after each word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_r <= '0;
      end_r  <= '0;
    end else if ((state_r == ST_IDLE) && i_start) begin
      addr_r <= i_first;
      end_r  <= i_last;
    end else if (addr_inc_s) begin
      addr_r <= addr_r + {{(p_addr_w-1){1'b0}}, 1'b1};
    end else begin
      addr_r <= addr_r;
    end
  end

  // Remember an abort raised while a byte is stalled, cleared once idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      abort_pend_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      abort_pend_r <= 1'b0;
    end else if (tx_active_s && i_abort) begin
      abort_pend_r <= 1'b1;
    end else begin
      abort_pend_r <= abort_pend_r;
    end
  end

  // Next-state decode plus serialiser load control.
  always_comb begin
    state_nxt_s    = state_r;
    ser_load_s     = 1'b0;
    ser_word_s     = i_scope_rdata;
    ser_last_idx_s = WORD_LAST_IDX;
    addr_inc_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt_s = ST_WAIT_SCOPE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_SCOPE: begin
        if (i_abort) begin
          state_nxt_s = ST_IDLE;
        end else if (i_scope_busy) begin
          state_nxt_s = ST_WAIT_SCOPE;
        end else begin
`ifdef X_SCOPE_DUMP_HDR_EN
          state_nxt_s    = ST_HDR;
          ser_load_s     = 1'b1;
          ser_word_s     = {8'h00, count16_s, HDR_SYNC};
          ser_last_idx_s = HDR_LAST_IDX;
`else
          state_nxt_s    = ST_READ;
`endif
        end
      end
      ST_HDR: begin
        if (byte_taken_s) begin
          if (stop_s) begin
            state_nxt_s = ST_IDLE;
          end else if (ser_last_s) begin
            state_nxt_s = ST_READ;
          end else begin
            state_nxt_s = ST_HDR;
          end
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_READ: begin
        if (i_abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (i_abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SEND;
          ser_load_s  = 1'b1;
        end
      end
      ST_SEND: begin
        if (byte_taken_s) begin
          if (stop_s) begin
            state_nxt_s = ST_IDLE;
          end else if (!ser_last_s) begin
            state_nxt_s = ST_SEND;
          end else if (addr_r == end_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_READ;
            addr_inc_s  = 1'b1;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  x_word_ser u_word_ser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (ser_load_s),
    .i_word     (ser_word_s),
    .i_last_idx (ser_last_idx_s),
    .i_adv      (byte_taken_s),
    .o_data     (ser_data_s),
    .o_last     (ser_last_s)
  );

  // Moore outputs, decoded from registered state only.
  assign o_busy        = (state_r != ST_IDLE);
  assign o_done        = (state_r == ST_DONE);
  assign o_scope_ren   = (state_r == ST_READ);
  assign o_scope_raddr = addr_r;
  assign o_tx_valid    = tx_active_s;
  assign o_tx_data     = tx_active_s ? ser_data_s : 8'h00;

endmodule

// File: tb/tb_x_scope_dump.sv
// Self-checking bench for x_scope_dump: randomized dumps compared against a
// byte-stream model built from the address range and a bench-side memory.
module tb_x_scope_dump;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [10:0] i_first = 11'd0;
  logic [10:0] i_last = 11'd0;
  logic        o_busy;
  logic        o_done;
  logic        i_scope_busy = 1'b0;
  logic        o_scope_ren;
  logic [10:0] o_scope_raddr;
  logic [31:0] i_scope_rdata;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_accept = 1'b0;

  logic [31:0] mem [0:2047];
  int n_err = 0;
  int n_chk = 0;

  x_scope_dump dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_first       (i_first),
    .i_last        (i_last),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .i_scope_busy  (i_scope_busy),
    .o_scope_ren   (o_scope_ren),
    .o_scope_raddr (o_scope_raddr),
    .i_scope_rdata (i_scope_rdata),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_accept   (i_tx_accept)
  );

  always #5 i_clk = ~i_clk;

  // Scope memory: one-cycle read latency, garbage on cycles with no read.
  always_ff @(posedge i_clk) begin
    if (o_scope_ren) i_scope_rdata <= mem[o_scope_raddr];
    else             i_scope_rdata <= $urandom;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One dump: builds the expected stream, drives it, then compares.
  task automatic run_dump(input int first, input int last, input int busy_cyc,
                          input int acc_mode, input int abort_at, input bit restart);
    logic [7:0] exp_b[$];
    int         exp_a[$];
    logic [7:0] got_b[$];
    int         got_a[$];
    int n, a, hdr_n, words, taken, stall, done_n, done_k, ren1, val1, exp_ren1;
    bit fin, prev_v, prev_acc;
    logic [7:0] prev_d;

    n = ((last - first) & 2047) + 1;
    hdr_n = 0;
`ifdef X_SCOPE_DUMP_HDR_EN
    hdr_n = 3;
    exp_b.push_back(8'hA5);
    exp_b.push_back(8'(n));
    exp_b.push_back(8'(n >> 8));
`endif
    for (int i = 0; i < n; i++) begin
      a = (first + i) & 2047;
      exp_a.push_back(a);
      for (int b = 0; b < 4; b++) exp_b.push_back(8'(mem[a] >> (8 * b)));
    end
    if (abort_at >= 0) begin
      words = (abort_at - hdr_n) / 4 + 1;
      while (exp_b.size() > abort_at + 1) void'(exp_b.pop_back());
      while (exp_a.size() > words) void'(exp_a.pop_back());
    end

    taken = 0; stall = 0; done_n = 0; done_k = -1; ren1 = -1; val1 = -1;
    fin = 1'b0; prev_v = 1'b0; prev_acc = 1'b0; prev_d = 8'h00;
    for (int k = 0; k < 40000 && !fin; k++) begin
      @(posedge i_clk);
      #1;
      i_start = (k == 0) || (restart && k == 5);
      if (k == 0) begin
        i_first = 11'(first);
        i_last  = 11'(last);
      end else begin
        i_first = 11'(first + 7);
        i_last  = 11'(first + 100);
      end
      i_scope_busy = (k < busy_cyc);
      if (abort_at >= 0 && taken == abort_at && o_tx_valid) begin
        stall++;
        i_abort     = 1'b1;
        i_tx_accept = (stall > 3);
      end else begin
        i_abort = 1'b0;
        case (acc_mode)
          1:       i_tx_accept = ($urandom_range(0, 2) == 0);
          default: i_tx_accept = 1'b1;
        endcase
      end
      @(negedge i_clk);
      if (prev_v && !prev_acc) begin
        check_eq("hold_valid", 32'(o_tx_valid), 32'd1);
        check_eq("hold_data", 32'(o_tx_data), 32'(prev_d));
      end
      prev_v = o_tx_valid; prev_acc = i_tx_accept; prev_d = o_tx_data;
      if (o_scope_ren) begin
        got_a.push_back(int'(o_scope_raddr));
        if (ren1 < 0) ren1 = k;
      end
      if (o_tx_valid && val1 < 0) val1 = k;
      if (o_tx_valid && i_tx_accept) begin
        got_b.push_back(o_tx_data);
        taken++;
      end
      if (o_done) begin
        done_n++;
        done_k = k;
      end
      if (k > 0 && !o_busy) fin = 1'b1;
    end
    i_start = 1'b0; i_abort = 1'b0; i_scope_busy = 1'b0;
    if (!fin) check_eq("timeout", 32'd0, 32'd1);

    check_eq("n_bytes", 32'(got_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      check_eq("byte", 32'(got_b[i]), 32'(exp_b[i]));
    check_eq("n_reads", 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
      check_eq("raddr", 32'(got_a[i]), 32'(exp_a[i]));
    check_eq("done_pulses", 32'(done_n), (abort_at >= 0) ? 32'd0 : 32'd1);
    check_eq("busy_end", 32'(o_busy), 32'd0);
`ifndef X_SCOPE_DUMP_HDR_EN
    if (acc_mode == 0 && abort_at < 0) begin
      exp_ren1 = (busy_cyc + 1 > 2) ? busy_cyc + 1 : 2;
      check_eq("first_ren_cycle", 32'(ren1), 32'(exp_ren1));
      check_eq("first_valid_cycle", 32'(val1), 32'(exp_ren1 + 2));
      check_eq("done_cycle", 32'(done_k), 32'(exp_ren1 + 6 * n));
    end
`endif
  endtask

  initial begin
    int f, l;
    // Spec pattern: word n holds bytes 4n..4n+3, LSB first.
    for (int n = 0; n < 2048; n++)
      mem[n] = {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    check_eq("rst_ren", 32'(o_scope_ren), 32'd0);
    check_eq("rst_raddr", 32'(o_scope_raddr), 32'd0);
    check_eq("rst_valid", 32'(o_tx_valid), 32'd0);
    check_eq("rst_data", 32'(o_tx_data), 32'd0);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);

    run_dump(0, 3, 0, 0, -1, 1'b0);      // bytes 00..0F, 26 cycles to done
    run_dump(0, 3, 0, 1, -1, 1'b0);      // accept 1 in 3, stalls held stable

    for (int n = 0; n < 2048; n++) mem[n] = $urandom;
    run_dump(2046, 1, 0, 0, -1, 1'b0);   // wrap through top address

    f = $urandom_range(0, 2047);
    l = (f + $urandom_range(0, 5)) & 2047;
    run_dump(f, l, 10, 0, -1, 1'b1);     // scope busy 10 cycles, restart ignored

`ifndef X_SCOPE_DUMP_HDR_EN
    run_dump(0, 3, 0, 0, 6, 1'b0);       // abort on byte 2 of word 1
`endif

    f = $urandom_range(0, 2047);
    run_dump(f, f, 0, 1, -1, 1'b0);      // single word

    for (int t = 0; t < 4; t++) begin
      f = $urandom_range(0, 2047);
      l = (f + $urandom_range(0, 7)) & 2047;
      run_dump(f, l, $urandom_range(0, 3), $urandom_range(0, 1), -1, 1'(t & 1));
    end

    run_dump(0, 2047, 0, 0, -1, 1'b0);   // whole memory

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
